dac_slew_ctrl: RTL and testbench
================================

# dac_slew_ctrl

Output stage between the voltage-to-code multiplier and the DAC pins of the SPGD actuator path. Accepts a signed 14-bit DAC code target over a valid/ready handshake and moves the registered DAC output toward it in bounded steps, so no actuator jump exceeds MAX_STEP per step interval. Once the target is reached, it waits a fixed settling time and then pulses SETTLED, which tells the SPGD loop that the ADC measurement for this perturbation may start.

## Interface
- DAC_WIDTH, 14, code width; two's complement.
- MAX_STEP, 64, largest code change per step; legal range 1 .. 2^(DAC_WIDTH-1).
- STEP_DIV, 4, clock cycles per step; legal values ≥1.
- SETTLE_CYCLES, 125, settling wait after the target is reached; legal values ≥1.
- CNT_WIDTH, 16, width of the step-divider and settle counters; must hold max(STEP_DIV, SETTLE_CYCLES).

Ports:
- CLK  in  1  single clock; everything is rising-edge.
- RST_N  in  1  synchronous, active-low reset.
- TARGET_CODE  in  DAC_WIDTH  requested code, signed.
- TARGET_VALID  in  1  TARGET_CODE is valid.
- TARGET_READY  out  1  high in IDLE; combinational from state.
- DAC_CODE  out  DAC_WIDTH  registered output code, signed.
- DAC_CODE_OB  out  DAC_WIDTH  offset-binary form for the DAC pins: {~DAC_CODE[MSB], DAC_CODE[MSB-1:0]}.
- BUSY  out  1  high in SLEW or SETTLE.
- SETTLED  out  1  registered one-cycle pulse when settling completes.

## Operation
- States: IDLE, SLEW, SETTLE.
- Reset (RST_N low at an edge) sets:
  - state = IDLE, DAC_CODE = 0 (DAC_CODE_OB = 0x2000), SETTLED = 0;
  - the target register and both counters to 0.
  - Reset is honoured in any state, including mid-slew; DAC_CODE jumps straight to 0.
- Handshake: a transfer occurs at an edge where TARGET_VALID & TARGET_READY & RST_N are all high.
  - TARGET_CODE is latched at that edge.
  - Once accepted, TARGET_CODE has no effect until the next transfer.
  - TARGET_VALID outside IDLE is ignored; upstream holds it until it sees TARGET_READY.
- IDLE to next state on a transfer:
  - target equals DAC_CODE: go to SETTLE, settle counter = 0;
  - otherwise: go to SLEW, divider = 0.
- SLEW:
  - The divider increments each cycle.
  - At the edge where divider == STEP_DIV-1, the divider returns to 0 and one step executes:
    - diff = target − DAC_CODE, computed in DAC_WIDTH+1 bits (no overflow possible);
    - if |diff| ≤ MAX_STEP: DAC_CODE = target, go to SETTLE, settle counter = 0;
    - else: DAC_CODE ± MAX_STEP, moving toward target.
  - DAC_CODE never overshoots the target and never wraps.
- SETTLE:
  - The counter increments each cycle.
  - At the edge where counter == SETTLE_CYCLES-1: go to IDLE and set SETTLED = 1 for exactly one cycle.
- The only way to abort a transaction is reset.

## Timing
- Transfer at edge k with n = ceil(|target − DAC_CODE| / MAX_STEP), n ≥ 1:
  - DAC_CODE updates at edges k + i·STEP_DIV, for i = 1..n;
  - SLEW→SETTLE happens at edge k + n·STEP_DIV;
  - IDLE is entered at edge k + n·STEP_DIV + SETTLE_CYCLES;
  - SETTLED and TARGET_READY are both high in the cycle that follows.
- Zero-distance target: SETTLE is entered at edge k; IDLE and SETTLED follow at edge k + SETTLE_CYCLES.
- Back-to-back: a new target may be accepted in the same cycle SETTLED is high, i.e. the first IDLE cycle.
- TARGET_READY is low from the cycle after a transfer until IDLE is re-entered.
- BUSY equals ~TARGET_READY.

## Test plan
- Reset release with TARGET_VALID low: DAC_CODE=0, DAC_CODE_OB=0x2000, TARGET_READY=1, BUSY=0, SETTLED=0; hold 50 cycles and confirm nothing changes.
- Defaults, DAC_CODE=0, accept 200 at edge k:
  - DAC_CODE reads 64/128/192/200 after edges k+4/8/12/16;
  - SETTLED is high only in the cycle after edge k+141.
- Full-scale negative swing: start at 8191, accept −8192:
  - 256 steps;
  - after 255 steps DAC_CODE = −8129, final step lands on −8192;
  - DAC_CODE_OB = 0x0000 at the end;
  - no intermediate value outside the range.
- Zero-distance: accept a target equal to DAC_CODE:
  - DAC_CODE never changes;
  - SETTLED is pulsed one cycle after edge k+125.
- Handshake: change TARGET_CODE and toggle TARGET_VALID during SLEW and SETTLE:
  - no effect on DAC_CODE or state;
  - a held-valid second target is accepted in the SETTLED cycle, and the next slew starts from it.
- Reset mid-operation: assert RST_N low during SLEW at DAC_CODE=128 (target 1000):
  - DAC_CODE=0 after that edge, state IDLE, no SETTLED pulse;
  - a following target is accepted normally.

Source files
------------

// File: rtl/dac_slew_ctrl.sv
// dac_slew_ctrl
// Output stage in front of the actuator DAC. It takes a signed target code over
// a valid/ready handshake and walks the registered DAC code toward it. Each step
// moves the code by at most MAX_STEP, and one step happens every STEP_DIV cycles.
// After the target is reached it waits SETTLE_CYCLES and then pulses settled_o.
// That pulse tells the loop that a measurement may start.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | ready for a new target; the DAC code holds
// SLEW   | stepping toward the latched target once every STEP_DIV cycles
// SETTLE | target reached; counting down the settling wait
//
// Ports:
//   clk_i           rising-edge clock
//   rst_n_i         synchronous active-low reset
//   target_code_i   requested code, two's complement
//   target_valid_i  target_code_i is valid
//   target_ready_o  high in IDLE
//   dac_code_o      registered output code, two's complement
//   dac_code_ob_o   offset-binary form of dac_code_o for the DAC pins
//   busy_o          high in SLEW or SETTLE
//   settled_o       one-cycle pulse when settling completes
module dac_slew_ctrl #(
    parameter int DAC_WIDTH     = 14,
    parameter int MAX_STEP      = 64,
    parameter int STEP_DIV      = 4,
    parameter int SETTLE_CYCLES = 125,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic signed [DAC_WIDTH-1:0] target_code_i,
    input  logic                        target_valid_i,
    output logic                        target_ready_o,
    output logic signed [DAC_WIDTH-1:0] dac_code_o,
    output logic        [DAC_WIDTH-1:0] dac_code_ob_o,
    output logic                        busy_o,
    output logic                        settled_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SLEW   = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    localparam logic signed [DAC_WIDTH:0]   MAX_STEP_W = (DAC_WIDTH+1)'(MAX_STEP);
    // The step can equal 2^(DAC_WIDTH-1), which is not representable as a
    // positive DAC_WIDTH-bit value. Modular add/subtract still gives the
    // right code, because the result always lies between the current code
    // and the target.
    localparam logic        [DAC_WIDTH-1:0] STEP_N     = DAC_WIDTH'(MAX_STEP);
    localparam logic        [CNT_WIDTH-1:0] DIV_LAST   = CNT_WIDTH'(STEP_DIV - 1);
    localparam logic        [CNT_WIDTH-1:0] SET_LAST   = CNT_WIDTH'(SETTLE_CYCLES - 1);

    state_t                        state_q;
    logic signed [DAC_WIDTH-1:0]   target_q;
    logic signed [DAC_WIDTH-1:0]   dac_q;
    logic        [CNT_WIDTH-1:0]   div_q;
    logic        [CNT_WIDTH-1:0]   settle_q;
    logic                          settled_q;

    logic signed [DAC_WIDTH:0]     diff_d;
    logic signed [DAC_WIDTH:0]     abs_d;
    logic        [DAC_WIDTH-1:0]   step_code_d;

    // Both operands are widened by one bit so that the difference cannot overflow.
    always_comb begin
        diff_d      = {target_q[DAC_WIDTH-1], target_q} - {dac_q[DAC_WIDTH-1], dac_q};
        abs_d       = diff_d[DAC_WIDTH] ? -diff_d : diff_d;
        step_code_d = diff_d[DAC_WIDTH] ? (dac_q - STEP_N) : (dac_q + STEP_N);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            target_q  <= '0;
            dac_q     <= '0;
            div_q     <= '0;
            settle_q  <= '0;
            settled_q <= 1'b0;
        end else begin
            settled_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (target_valid_i) begin
                        target_q <= target_code_i;
                        if (target_code_i == dac_q) begin
                            state_q  <= S_SETTLE;
                            settle_q <= '0;
                        end else begin
                            state_q <= S_SLEW;
                            div_q   <= '0;
                        end
                    end
                end
                S_SLEW: begin
                    if (div_q == DIV_LAST) begin
                        div_q <= '0;
                        if (abs_d <= MAX_STEP_W) begin
                            dac_q    <= target_q;
                            state_q  <= S_SETTLE;
                            settle_q <= '0;
                        end else begin
                            dac_q <= step_code_d;
                        end
                    end else begin
                        div_q <= div_q + 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (settle_q == SET_LAST) begin
                        state_q   <= S_IDLE;
                        settle_q  <= '0;
                        settled_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign target_ready_o = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign dac_code_o     = dac_q;
    assign dac_code_ob_o  = {~dac_q[DAC_WIDTH-1], dac_q[DAC_WIDTH-2:0]};
    assign settled_o      = settled_q;

endmodule

// File: tb/tb_dac_slew_ctrl.sv
// Bench for dac_slew_ctrl. A transaction-level model predicts every output
// from the transfer edge, the start code and the target. Directed scenarios
// pin known values, and a randomized phase follows them.
module tb_dac_slew_ctrl;
    localparam int W  = 14;
    localparam int MS = 64;
    localparam int SD = 4;
    localparam int SC = 125;

    logic                clk = 1'b0;
    logic                rst_n;
    logic signed [W-1:0] code;
    logic                valid;
    logic                ready;
    logic signed [W-1:0] dac;
    logic        [W-1:0] ob;
    logic                busy;
    logic                settled;

    int n_checks = 0;
    int n_pass   = 0;

    dac_slew_ctrl #(
        .DAC_WIDTH(W), .MAX_STEP(MS), .STEP_DIV(SD), .SETTLE_CYCLES(SC), .CNT_WIDTH(16)
    ) dut (
        .clk_i(clk), .rst_n_i(rst_n), .target_code_i(code), .target_valid_i(valid),
        .target_ready_o(ready), .dac_code_o(dac), .dac_code_ob_o(ob),
        .busy_o(busy), .settled_o(settled)
    );

    always #5 clk = ~clk;

    // Transaction-level reference model.
    int edge_n = 0;
    int m_k, m_s, m_t, m_n, m_done = -1, m_settled_edge = -1;
    int m_dac = 0;
    bit m_idle = 1'b1;

    always @(posedge clk) begin
        int steps, d;
        edge_n = edge_n + 1;
        if (!rst_n) begin
            m_idle = 1'b1; m_dac = 0; m_done = -1; m_settled_edge = -1;
        end else if (!m_idle) begin
            steps = (edge_n - m_k) / SD;
            if (steps >= m_n) m_dac = m_t;
            else if (m_t > m_s) m_dac = m_s + steps * MS;
            else m_dac = m_s - steps * MS;
            if (edge_n == m_done) begin
                m_idle = 1'b1;
                m_settled_edge = edge_n;
            end
        end else if (valid) begin
            m_k = edge_n; m_s = m_dac; m_t = int'(code);
            d = (m_t > m_s) ? m_t - m_s : m_s - m_t;
            m_n = (d + MS - 1) / MS;
            m_done = m_k + m_n * SD + SC;
            m_idle = 1'b0;
        end
    end

    task automatic check(input string nm, input int act, input int exp);
        n_checks = n_checks + 1;
        if (act == exp) n_pass = n_pass + 1;
        else $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    endtask

    // Compare process: the model is checked against the DUT on every cycle.
    always @(negedge clk) begin
        if (edge_n >= 1) begin
            check("dac_code", int'(dac), m_dac);
            check("dac_code_ob", int'(ob), m_dac + (1 << (W-1)));
            check("target_ready", int'(ready), int'(m_idle));
            check("busy", int'(busy), int'(!m_idle));
            check("settled", int'(settled), int'(m_settled_edge == edge_n));
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            if (m_idle) return;
            @(posedge clk); #1;
        end
        check("wait_idle_timeout", 0, 1);
    endtask

    // Presents a target at a negedge. The transfer happens at the following
    // edge, and the task returns 1 time unit after that edge.
    task automatic accept(input int tgt);
        @(negedge clk);
        code  = W'(tgt);
        valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int tt;
        rst_n = 1'b0; valid = 1'b0; code = '0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        check("rst_dac", int'(dac), 0);
        check("rst_ob", int'(ob), 'h2000);
        check("rst_ready", int'(ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_settled", int'(settled), 0);
        repeat (50) @(negedge clk);
        #1;
        check("hold_dac", int'(dac), 0);
        check("hold_ready", int'(ready), 1);

        // Slew from 0 to 200 with the default parameters.
        accept(200);
        edges(4);   check("t200_k4", int'(dac), 64);
        edges(4);   check("t200_k8", int'(dac), 128);
        edges(4);   check("t200_k12", int'(dac), 192);
        edges(4);   check("t200_k16", int'(dac), 200);
        edges(124); check("t200_k140_settled", int'(settled), 0);
        edges(1);   check("t200_k141_settled", int'(settled), 1);
        edges(1);   check("t200_k142_settled", int'(settled), 0);
        check("t200_k142_ready", int'(ready), 1);

        // Full-scale negative swing.
        accept(8191);
        wait_idle();
        accept(-8192);
        edges(255 * SD); check("fs_255", int'(dac), -8129);
        edges(SD);       check("fs_256", int'(dac), -8192);
        check("fs_ob", int'(ob), 0);
        wait_idle();

        // Zero-distance target.
        accept(-8192);
        edges(SC - 1); check("zd_k124_settled", int'(settled), 0);
        check("zd_busy", int'(busy), 1);
        edges(1);      check("zd_k125_settled", int'(settled), 1);
        check("zd_dac", int'(dac), -8192);

        // Handshake noise during SLEW/SETTLE, then a held second target.
        accept(500);
        for (int i = 0; i < 5000 && (m_done - edge_n > 3); i++) begin
            @(negedge clk);
            valid = 1'($urandom);
            code  = W'($urandom);
        end
        @(negedge clk);
        valid = 1'b1; code = W'(-300);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (m_settled_edge == edge_n) break;
        end
        check("hs_settled", int'(settled), 1);
        check("hs_dac", int'(dac), 500);
        check("hs_ready", int'(ready), 1);
        @(posedge clk); #1;
        valid = 1'b0;
        check("hs_accepted_busy", int'(busy), 1);
        edges(SD); check("hs_first_step", int'(dac), 436);
        wait_idle();

        // Reset in the middle of a slew.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        accept(1000);
        edges(2 * SD); check("rs_pre", int'(dac), 128);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        check("rs_dac", int'(dac), 0);
        check("rs_ready", int'(ready), 1);
        check("rs_settled", int'(settled), 0);
        @(negedge clk); rst_n = 1'b1;
        edges(200);
        accept(-77);
        wait_idle();
        check("rs_after", int'(dac), -77);

        // Randomized transactions, with occasional resets.
        for (int i = 0; i < 30; i++) begin
            wait_idle();
            edges($urandom_range(0, 4));
            if (i % 4 == 0) tt = int'($urandom_range(0, 16383)) - 8192;
            else begin
                tt = m_dac + int'($urandom_range(0, 1200)) - 600;
                if (tt > 8191) tt = 8191;
                if (tt < -8192) tt = -8192;
            end
            accept(tt);
            if ($urandom_range(0, 7) == 0) begin
                edges($urandom_range(1, 60));
                @(negedge clk); rst_n = 1'b0;
                @(negedge clk); rst_n = 1'b1;
            end
        end
        wait_idle();
        edges(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
